tqvp_prism_infilt: RTL and testbench
====================================

Name: tqvp_prism_infilt

Overview:
- Input-conditioning stage directly upstream of the PRISM peripheral. It sits between the raw ui_in[6:0] pins and the PRISM in_data[6:0] inputs.
- Provides per-bit glitch filtering (prescaled, programmable threshold), sticky edge capture and an edge interrupt.
- Register-mapped on the same 6-bit TinyQV peripheral bus, at word addresses 0x30/0x34/0x38.
- filt_out drives PRISM inputs. edge_flag is available as extra PRISM inputs. edge_ack comes back from PRISM outputs.

Parameters:
- WIDTH, 7, number of conditioned input bits (1..8).
- CNT_BITS, 4, width of each filter counter and of the threshold field.

Ports:
- clk  in  1  system clock (64 MHz nominal)
- rst_n  in  1  reset. Asynchronous, active-low.
- pin_in  in  WIDTH  raw pin levels (already 2-flop synchronised by the core)
- address  in  6  peripheral register address
- data_in  in  32  write data
- data_write_n  in  2  11 = no write. Only 10 (32-bit) writes are accepted.
- edge_ack  in  WIDTH  per-bit single-cycle clear of edge_flag (from PRISM outputs)
- filt_out  out  WIDTH  filtered levels to PRISM in_data
- edge_flag  out  WIDTH  sticky edge-detected flags
- rd_data  out  32  read data for the addressed register. 0 if address is not owned.
- rd_hit  out  1  high when address is 0x30, 0x34 or 0x38 (combinational)
- irq  out  1  |(edge_flag & irq_en), registered

Behaviour:
- Registers (32-bit writes only; 8/16-bit writes are ignored):
  - 0x30 CFG, R/W: [6:0] filt_en, [14:8] edge_pol (1 = rising, 0 = falling), [22:16] irq_en, [27:24] threshold.
  - 0x34 PRESC, R/W: [7:0] prescale. Reads return 0 in [31:8].
  - 0x38 STAT: read returns [6:0] edge_flag, [14:8] pin_in, [22:16] filt_out. Write-1-to-clear on [6:0]; other bits are ignored.
  - Unused bits read 0.
- Reset (async): all CFG/PRESC fields 0, prescaler counter 0, all filter counters 0, filt_out 0, edge_flag 0, irq 0.
- Prescaler:
  - 8-bit counter pc. tick = (pc == prescale).
  - On tick pc <= 0, else pc <= pc + 1.
  - prescale = 0 gives a tick every cycle.
  - A write to PRESC resets pc to 0 in the same cycle.
- Filter disabled (filt_en[i] = 0): filt_out[i] <= pin_in[i] every cycle (1-cycle latency). cnt[i] held at 0.
- Filter enabled, per bit, evaluated every cycle:
  - Match (pin_in[i] == filt_out[i]): cnt[i] <= 0, regardless of tick.
  - Mismatch, no tick: cnt[i] holds.
  - Mismatch with tick, where T_eff = max(threshold, 1):
    - if cnt[i] >= T_eff - 1: filt_out[i] <= pin_in[i] and cnt[i] <= 0;
    - else cnt[i] <= cnt[i] + 1.
  - Net effect: a change must persist for T_eff consecutive ticks to propagate.
- Threshold changed mid-count: cnt is not cleared. If cnt >= new T_eff - 1, the transfer happens on the next mismatching tick.
- Toggling filt_en[i]: the bit switches mode on the next cycle and cnt[i] is cleared.
- Edge detect:
  - Triggered at any clock edge where filt_out[i] changes.
  - Rising (0->1) sets edge_flag[i] if edge_pol[i] = 1. Falling (1->0) sets it if edge_pol[i] = 0.
  - The flag becomes visible in the same cycle as the new filt_out value.
  - Filter-disabled bits also generate edges.
- Flag clear: edge_ack[i] = 1 or a STAT write with data_in[i] = 1 clears the flag at the next edge.
- Simultaneous set and clear on the same bit in the same cycle: set wins, flag stays 1.
- irq: registered one cycle after the flag/irq_en change. Falls one cycle after the last enabled flag clears.
- Read path is combinational from address. There are no read side effects.

Test Plan:
- Bypass latency: reset, CFG = 0, pin_in[2] 0->1 at cycle 10 -> filt_out[2] = 1 at cycle 11. No edge_flag, since edge_pol[2] = 0 selects falling. Then pin_in[2] 1->0 -> edge_flag[2] = 1 one cycle later.
- Glitch reject: CFG filt_en = 0x01, threshold = 4, PRESC = 0, pin_in[0] = 1 for 3 cycles then 0 -> filt_out[0] stays 0. Hold 1 for 4 cycles -> filt_out[0] = 1 on the 4th edge after the rise.
- Prescale: PRESC = 3, threshold = 2, filt_en[1] = 1, pin_in[1] held high -> filt_out[1] rises after exactly 2 ticks (5-8 cycles depending on pc phase). The bench checks against the model pc.
- Edge + irq + W1C: edge_pol[5] = 1, irq_en[5] = 1, rising edge on bit 5 -> edge_flag[5] = 1, irq = 1 the next cycle. Write STAT = 0x20 -> flag 0, irq 0 one cycle later. STAT read [22:16] bit 5 = 1.
- Set/clear collision: hold edge_ack[3] = 1 on the same cycle as a rising edge with edge_pol[3] = 1 -> edge_flag[3] = 1. Next-cycle edge_ack[3] -> 0.
- Async reset mid-count: threshold = 8, cnt[0] = 5, assert rst_n low between clock edges -> all outputs 0 immediately, CFG reads 0 after release. 8-bit writes to 0x30 are ignored.

Source files
------------

// File: rtl/tqvp_prism_infilt_if.sv
// TinyQV peripheral register bus as seen by the input-filter block.
// Latency: read data/hit are combinational from address; writes land on the next clk edge.
// Backpressure: none; every 32-bit write to an owned address is accepted in its cycle.
interface tqvp_prism_infilt_if;
   logic [5:0]  address;
   logic [31:0] data_in;
   logic [1:0]  data_write_n;
   logic [31:0] rd_data;
   logic        rd_hit;

   // Bus master (CPU side) drives address/write data and receives read data
   modport master (
      output address, data_in, data_write_n,
      input  rd_data, rd_hit
   );

   // Peripheral side
   modport slave (
      input  address, data_in, data_write_n,
      output rd_data, rd_hit
   );
endinterface

// File: rtl/tqvp_prism_infilt.sv
// Per-bit glitch filter, sticky edge capture and edge irq between ui_in pins and PRISM in_data.
// Latency: bypassed bits 1 cycle; filtered bits need T_eff consecutive mismatching prescaler ticks.
// Backpressure: none; register writes always accepted, reads combinational with no side effects.
module tqvp_prism_infilt #(
   parameter int WIDTH    = 7,
   parameter int CNT_BITS = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [WIDTH-1:0]    pin_in_i,
   input  logic [WIDTH-1:0]    edge_ack_i,
   output logic [WIDTH-1:0]    filt_out_o,
   output logic [WIDTH-1:0]    edge_flag_o,
   output logic                irq_o,
   tqvp_prism_infilt_if.slave  bus
);

   localparam logic [5:0] ADDR_CFG   = 6'h30;
   localparam logic [5:0] ADDR_PRESC = 6'h34;
   localparam logic [5:0] ADDR_STAT  = 6'h38;

   // Configuration state
   logic [WIDTH-1:0]    filt_en_q;
   logic [WIDTH-1:0]    edge_pol_q;
   logic [WIDTH-1:0]    irq_en_q;
   logic [CNT_BITS-1:0] thr_q;
   logic [7:0]          presc_q;

   // Datapath state
   logic [7:0]          pc_q, pc_d;
   logic [WIDTH-1:0]    filt_q, filt_d;
   logic [WIDTH-1:0]    flag_q, flag_d;
   logic [CNT_BITS-1:0] cnt_q [WIDTH];
   logic [CNT_BITS-1:0] cnt_d [WIDTH];
   logic                irq_q, irq_d;

   logic                wr_en, cfg_wr, presc_wr, stat_wr;
   logic                tick;
   logic [CNT_BITS-1:0] thr_m1;
   logic [WIDTH-1:0]    rise, fall, set_v, clr_v;
   logic [31:0]         rd_data;
   logic                rd_hit;
   logic                unused_data;

   // Only full 32-bit writes (data_write_n = 10) are honoured
   assign wr_en    = (bus.data_write_n == 2'b10);
   assign cfg_wr   = wr_en && (bus.address == ADDR_CFG);
   assign presc_wr = wr_en && (bus.address == ADDR_PRESC);
   assign stat_wr  = wr_en && (bus.address == ADDR_STAT);

   assign unused_data = ^bus.data_in;

   // Configuration registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filt_en_q  <= '0;
         edge_pol_q <= '0;
         irq_en_q   <= '0;
         thr_q      <= '0;
         presc_q    <= '0;
      end else begin
         if (cfg_wr) begin
            filt_en_q  <= bus.data_in[WIDTH-1:0];
            edge_pol_q <= bus.data_in[8 +: WIDTH];
            irq_en_q   <= bus.data_in[16 +: WIDTH];
            thr_q      <= bus.data_in[24 +: CNT_BITS];
         end
         if (presc_wr) begin
            presc_q <= bus.data_in[7:0];
         end
      end
   end

   // Prescaler, filter counters, edge flags and irq next-state
   always_comb begin
      tick   = (pc_q == presc_q);
      // Threshold 0 behaves like 1, so the transfer point is max(thr,1)-1
      thr_m1 = (thr_q == '0) ? '0 : thr_q - 1'b1;

      if (presc_wr || tick) pc_d = 8'd0;
      else                  pc_d = pc_q + 8'd1;

      filt_d = filt_q;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = cnt_q[i];
         if (!filt_en_q[i]) begin
            filt_d[i] = pin_in_i[i];
            cnt_d[i]  = '0;
         end else if (pin_in_i[i] == filt_q[i]) begin
            cnt_d[i] = '0;
         end else if (tick) begin
            if (cnt_q[i] >= thr_m1) begin
               filt_d[i] = pin_in_i[i];
               cnt_d[i]  = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
         // Changing a bit's filter mode restarts its count
         if (cfg_wr && (bus.data_in[i] != filt_en_q[i])) cnt_d[i] = '0;
      end

      rise   = filt_d & ~filt_q;
      fall   = ~filt_d & filt_q;
      set_v  = (rise & edge_pol_q) | (fall & ~edge_pol_q);
      clr_v  = edge_ack_i | (stat_wr ? bus.data_in[WIDTH-1:0] : '0);
      // Set is applied last so a coincident clear loses
      flag_d = (flag_q & ~clr_v) | set_v;
      irq_d  = |(flag_q & irq_en_q);
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q   <= '0;
         filt_q <= '0;
         flag_q <= '0;
         irq_q  <= 1'b0;
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      end else begin
         pc_q   <= pc_d;
         filt_q <= filt_d;
         flag_q <= flag_d;
         irq_q  <= irq_d;
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   // Combinational register read mux
   always_comb begin
      rd_data = '0;
      rd_hit  = 1'b0;
      case (bus.address)
         ADDR_CFG: begin
            rd_hit                  = 1'b1;
            rd_data[WIDTH-1:0]      = filt_en_q;
            rd_data[8 +: WIDTH]     = edge_pol_q;
            rd_data[16 +: WIDTH]    = irq_en_q;
            rd_data[24 +: CNT_BITS] = thr_q;
         end
         ADDR_PRESC: begin
            rd_hit       = 1'b1;
            rd_data[7:0] = presc_q;
         end
         ADDR_STAT: begin
            rd_hit               = 1'b1;
            rd_data[WIDTH-1:0]   = flag_q;
            rd_data[8 +: WIDTH]  = pin_in_i;
            rd_data[16 +: WIDTH] = filt_q;
         end
         default: ;
      endcase
   end

   assign bus.rd_data  = rd_data;
   assign bus.rd_hit   = rd_hit;
   assign filt_out_o   = filt_q;
   assign edge_flag_o  = flag_q;
   assign irq_o        = irq_q;

endmodule

// File: tb/tb_tqvp_prism_infilt.sv
// Directed + randomized bench for the PRISM input filter against a cycle-level rule model.
// Latency: outputs sampled 1 time unit after each rising clk edge.
// Backpressure: none modelled; the bus always accepts.
module tb_tqvp_prism_infilt;
   localparam int W = 7;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] pin_in = '0;
   logic [W-1:0] edge_ack = '0;
   logic [W-1:0] filt_out_o, edge_flag_o;
   logic         irq_o;

   tqvp_prism_infilt_if bus();

   tqvp_prism_infilt #(.WIDTH(W), .CNT_BITS(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pin_in_i    (pin_in),
      .edge_ack_i  (edge_ack),
      .filt_out_o  (filt_out_o),
      .edge_flag_o (edge_flag_o),
      .irq_o       (irq_o),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;
   int fails  = 0;

   // Reference model state
   logic [W-1:0] m_en, m_pol, m_irqen, m_filt, m_flag;
   int           m_thr, m_presc, m_pc;
   int           m_cnt [W];
   bit           m_irq;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_en = '0; m_pol = '0; m_irqen = '0; m_filt = '0; m_flag = '0;
      m_thr = 0; m_presc = 0; m_pc = 0; m_irq = 0;
      for (int i = 0; i < W; i++) m_cnt[i] = 0;
   endtask

   function automatic logic [31:0] m_read(logic [5:0] a);
      logic [31:0] r = '0;
      case (a)
         6'h30: begin
            r[6:0] = m_en; r[14:8] = m_pol; r[22:16] = m_irqen; r[27:24] = 4'(m_thr);
         end
         6'h34: r[7:0] = 8'(m_presc);
         6'h38: begin
            r[6:0] = m_flag; r[14:8] = pin_in; r[22:16] = m_filt;
         end
         default: r = '0;
      endcase
      return r;
   endfunction

   task automatic compare_all();
      logic hit;
      hit = (bus.address == 6'h30) || (bus.address == 6'h34) || (bus.address == 6'h38);
      chk("filt_out", 32'(filt_out_o), 32'(m_filt));
      chk("edge_flag", 32'(edge_flag_o), 32'(m_flag));
      chk("irq", 32'(irq_o), 32'(m_irq));
      chk("rd_hit", 32'(bus.rd_hit), 32'(hit));
      chk("rd_data", bus.rd_data, m_read(bus.address));
   endtask

   // Advance one clock: predict from the rules using the inputs present now, then compare
   task automatic step();
      logic [W-1:0] nf, nflag, setv, clrv, nen, npol, nirqen;
      int           ncnt [W];
      int           teff, npc, nthr, npresc;
      bit           tick, wr, nirq;
      logic [31:0]  d;
      d = bus.data_in;
      nf = m_filt; nen = m_en; npol = m_pol; nirqen = m_irqen;
      nthr = m_thr; npresc = m_presc; npc = m_pc; nflag = m_flag; nirq = m_irq;
      for (int i = 0; i < W; i++) ncnt[i] = m_cnt[i];
      if (rst_n) begin
         wr   = (bus.data_write_n == 2'b10);
         tick = (m_pc == m_presc);
         teff = (m_thr == 0) ? 1 : m_thr;
         for (int i = 0; i < W; i++) begin
            if (!m_en[i]) begin
               nf[i] = pin_in[i]; ncnt[i] = 0;
            end else if (pin_in[i] == m_filt[i]) begin
               ncnt[i] = 0;
            end else if (tick) begin
               // this tick would be the teff-th consecutive one
               if (m_cnt[i] + 1 >= teff) begin nf[i] = pin_in[i]; ncnt[i] = 0; end
               else ncnt[i] = m_cnt[i] + 1;
            end
         end
         npc = tick ? 0 : (m_pc + 1) % 256;
         clrv = edge_ack;
         if (wr && bus.address == 6'h30) begin
            for (int i = 0; i < W; i++) if (d[i] != m_en[i]) ncnt[i] = 0;
            nen = d[6:0]; npol = d[14:8]; nirqen = d[22:16]; nthr = int'(d[27:24]);
         end
         if (wr && bus.address == 6'h34) begin
            npresc = int'(d[7:0]); npc = 0;
         end
         if (wr && bus.address == 6'h38) clrv = clrv | d[6:0];
         setv = '0;
         for (int i = 0; i < W; i++) begin
            if (nf[i] != m_filt[i]) setv[i] = (nf[i] == m_pol[i]);
         end
         nflag = (m_flag & ~clrv) | setv;
         nirq  = |(m_flag & m_irqen);
      end
      @(posedge clk);
      #1;
      if (rst_n) begin
         m_filt = nf; m_en = nen; m_pol = npol; m_irqen = nirqen; m_thr = nthr;
         m_presc = npresc; m_pc = npc; m_flag = nflag; m_irq = nirq;
         for (int i = 0; i < W; i++) m_cnt[i] = ncnt[i];
      end
      compare_all();
   endtask

   task automatic wr(logic [5:0] a, logic [31:0] d, logic [1:0] wn = 2'b10);
      bus.address = a; bus.data_in = d; bus.data_write_n = wn;
      step();
      bus.data_write_n = 2'b11;
   endtask

   initial begin
      int n;
      int r;
      bus.address = 6'h30; bus.data_in = '0; bus.data_write_n = 2'b11;
      model_reset();

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      compare_all();
      chk("rst_filt", 32'(filt_out_o), 32'd0);
      rst_n = 1'b1;

      // Bypass latency and falling-edge flag
      repeat (8) step();
      pin_in[2] = 1'b1;
      step();
      chk("byp_rise", 32'(filt_out_o[2]), 32'd1);
      chk("byp_rise_noflag", 32'(edge_flag_o[2]), 32'd0);
      pin_in[2] = 1'b0;
      step();
      chk("byp_fall_flag", 32'(edge_flag_o[2]), 32'd1);
      edge_ack[2] = 1'b1;
      step();
      edge_ack = '0;
      chk("ack_clear", 32'(edge_flag_o[2]), 32'd0);

      // Glitch reject at threshold 4, tick every cycle
      wr(6'h30, 32'h0400_0001);
      pin_in[0] = 1'b1;
      repeat (3) step();
      pin_in[0] = 1'b0;
      repeat (3) step();
      chk("glitch_rej", 32'(filt_out_o[0]), 32'd0);
      pin_in[0] = 1'b1;
      repeat (3) step();
      chk("glitch_3rd", 32'(filt_out_o[0]), 32'd0);
      step();
      chk("glitch_4th", 32'(filt_out_o[0]), 32'd1);

      // Prescaled filter: two ticks of a /4 prescaler
      wr(6'h34, 32'd3);
      wr(6'h30, 32'h0200_0002);
      pin_in[1] = 1'b1;
      n = 0;
      for (int k = 1; k <= 12; k++) begin
         step();
         if (filt_out_o[1]) begin n = k; break; end
      end
      chk("presc_lat_range", 32'((n >= 5) && (n <= 8)), 32'd1);

      // Rising edge on bit 5, irq, then W1C
      wr(6'h30, (32'h1 << 13) | (32'h1 << 21));
      wr(6'h34, 32'd0);
      pin_in[5] = 1'b1;
      bus.address = 6'h38;
      step();
      chk("e5_flag", 32'(edge_flag_o[5]), 32'd1);
      chk("e5_irq_early", 32'(irq_o), 32'd0);
      step();
      chk("e5_irq", 32'(irq_o), 32'd1);
      chk("stat_filt5", 32'(bus.rd_data[21]), 32'd1);
      wr(6'h38, 32'h20);
      chk("w1c_flag", 32'(edge_flag_o[5]), 32'd0);
      step();
      chk("w1c_irq", 32'(irq_o), 32'd0);

      // Set/clear collision on bit 3
      wr(6'h30, (32'h1 << 11) | (32'h1 << 13) | (32'h1 << 21));
      pin_in[3] = 1'b1;
      edge_ack[3] = 1'b1;
      step();
      chk("coll_set_wins", 32'(edge_flag_o[3]), 32'd1);
      edge_ack[3] = 1'b0;
      step();
      edge_ack[3] = 1'b1;
      step();
      edge_ack = '0;
      chk("coll_ack_next", 32'(edge_flag_o[3]), 32'd0);

      // Unowned addresses
      bus.address = 6'h3C;
      #1;
      chk("miss_hit", 32'(bus.rd_hit), 32'd0);
      chk("miss_data", bus.rd_data, 32'd0);

      // Randomized phase
      for (int c = 0; c < 600; c++) begin
         r = $urandom_range(0, 99);
         if (r < 3) begin
            wr(6'h30, $urandom);
         end else if (r < 5) begin
            wr(6'h34, ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 3)));
         end else if (r < 7) begin
            wr(6'h38, $urandom);
         end else if (r < 9) begin
            wr(6'h30, $urandom, 2'($urandom_range(0, 1)));
         end else begin
            if ($urandom_range(0, 3) == 0) pin_in = pin_in ^ (7'(1) << $urandom_range(0, W - 1));
            edge_ack = ($urandom_range(0, 9) == 0) ? 7'($urandom) : '0;
            case ($urandom_range(0, 4))
               0: bus.address = 6'h30;
               1: bus.address = 6'h34;
               2: bus.address = 6'h38;
               3: bus.address = 6'h3C;
               default: bus.address = 6'($urandom);
            endcase
            step();
         end
      end
      edge_ack = '0;

      // Async reset in the middle of a count
      wr(6'h30, 32'h1 << 20);
      wr(6'h34, 32'd0);
      pin_in = '0;
      repeat (2) step();
      pin_in[4] = 1'b1;
      step();
      pin_in[4] = 1'b0;
      step();
      step();
      chk("pre_rst_irq", 32'(irq_o), 32'd1);
      wr(6'h30, 32'h0810_0001);
      pin_in[0] = 1'b1;
      repeat (5) step();
      chk("midcount_hold", 32'(filt_out_o[0]), 32'd0);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_filt", 32'(filt_out_o), 32'd0);
      chk("arst_flag", 32'(edge_flag_o), 32'd0);
      chk("arst_irq", 32'(irq_o), 32'd0);
      model_reset();
      compare_all();
      repeat (2) step();
      rst_n = 1'b1;
      bus.address = 6'h30;
      #1;
      chk("cfg_after_rst", bus.rd_data, 32'd0);
      wr(6'h30, 32'hFFFF_FFFF, 2'b00);
      chk("byte_wr_ign", bus.rd_data, 32'd0);
      wr(6'h30, 32'hFFFF_FFFF, 2'b01);
      chk("half_wr_ign", bus.rd_data, 32'd0);
      repeat (3) step();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
